// File: rtl/rr_request_agent_if.sv
// Request/grant bundle between channel sources, the request agent and the arbiter.
interface rr_request_agent_if #(
  parameter int unsigned channels = 8,
  parameter int unsigned STAT_W   = 32
);
  logic [channels-1:0] enq;
  logic                clr_err;
  logic [channels-1:0] grant;
  logic [channels-1:0] request;
  logic [channels-1:0] served;
  logic [channels-1:0] busy;
  logic [channels-1:0] overflow;
  logic                grant_err;
  logic [STAT_W-1:0]   total_grants;

  // Agent side
  modport master (
    input  enq, clr_err, grant,
    output request, served, busy, overflow, grant_err, total_grants
  );

  // Source/arbiter side
  modport slave (
    output enq, clr_err, grant,
    input  request, served, busy, overflow, grant_err, total_grants
  );
endinterface

// File: rtl/rr_request_agent.sv
// Requester-side agent: per-channel pending counters drive the request vector,
// the one-hot grant retires work, and grant-bus protocol errors are flagged.
module rr_request_agent #(
  parameter int unsigned channels = 8,
  parameter int unsigned CNT_W    = 4,
  parameter int unsigned STAT_W   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  rr_request_agent_if.master    bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    SERVE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]    pending_q [channels];
  logic [CNT_W-1:0]    pend_nxt  [channels];
  state_t              state_q   [channels];
  logic [channels-1:0] req_c;
  logic [channels-1:0] valid_c;
  logic [channels-1:0] ovf_set_c;
  logic                grant_multi_c;
  logic                grant_stray_c;
  logic                illegal_c;
  logic [channels-1:0] served_q;
  logic [channels-1:0] busy_q;
  logic [channels-1:0] overflow_q;
  logic                grant_err_q;
  logic [STAT_W-1:0]   total_q;

  // Request is a pure decode of the pending counters
  always_comb begin
    req_c = '0;
    for (int i = 0; i < channels; i++) begin
      req_c[i] = (pending_q[i] != '0);
    end
  end

  // Grant legality: at most one bit set, and only on a requesting channel
  always_comb begin
    grant_multi_c = |(bus.grant & (bus.grant - channels'(1)));
    grant_stray_c = |(bus.grant & ~req_c);
    illegal_c     = grant_multi_c | grant_stray_c;
    valid_c       = illegal_c ? '0 : bus.grant;
  end

  // Next pending value per channel; an illegal grant freezes all counters
  always_comb begin
    ovf_set_c = '0;
    for (int i = 0; i < channels; i++) begin
      pend_nxt[i] = pending_q[i];
      if (!illegal_c) begin
        if (valid_c[i] && !bus.enq[i]) begin
          pend_nxt[i] = pending_q[i] - CNT_W'(1);
        end else if (bus.enq[i] && !valid_c[i]) begin
          if (pending_q[i] == CNT_MAX) begin
            ovf_set_c[i] = 1'b1;
          end else begin
            pend_nxt[i] = pending_q[i] + CNT_W'(1);
          end
        end
      end
    end
  end

  // Per-channel FSM, counters, sticky flags and statistics
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < channels; i++) begin
        pending_q[i] <= '0;
        state_q[i]   <= IDLE;
      end
      served_q    <= '0;
      busy_q      <= '0;
      overflow_q  <= '0;
      grant_err_q <= 1'b0;
      total_q     <= '0;
    end else begin
      for (int i = 0; i < channels; i++) begin
        pending_q[i] <= pend_nxt[i];
        if (pend_nxt[i] == '0) begin
          state_q[i] <= IDLE;
          busy_q[i]  <= 1'b0;
        end else if (valid_c[i]) begin
          state_q[i] <= SERVE;
          busy_q[i]  <= 1'b1;
        end else begin
          state_q[i] <= REQ;
          busy_q[i]  <= 1'b0;
        end
        if (ovf_set_c[i]) begin
          overflow_q[i] <= 1'b1;
        end else if (bus.clr_err) begin
          overflow_q[i] <= 1'b0;
        end
      end
      served_q <= valid_c;
      if (illegal_c) begin
        grant_err_q <= 1'b1;
      end else if (bus.clr_err) begin
        grant_err_q <= 1'b0;
      end
      if (|valid_c) begin
        total_q <= total_q + STAT_W'(1);
      end
    end
  end

  assign bus.request      = req_c;
  assign bus.served       = served_q;
  assign bus.busy         = busy_q;
  assign bus.overflow     = overflow_q;
  assign bus.grant_err    = grant_err_q;
  assign bus.total_grants = total_q;

endmodule
